vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
Transaction controller for the vending machine. It debounces and edge-detects the raw nickel/dime/quarter inputs and accumulates credit. It accepts a product selection, issues the vend strobe, then pays out change coin by coin through the change hopper. It also handles cancel and inactivity timeout by refunding the full credit, and sits between the coin acceptor sensors and the product and change mechanisms.

Parameters:
PRICE0, 25, price of product 0 in cents
PRICE1, 50, price of product 1 in cents
PRICE2, 65, price of product 2 in cents
PRICE3, 100, price of product 3 in cents
MAX_CREDIT, 195, largest credit accepted in cents; must be a multiple of 5 and ≤ 511
TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund
GAP_CYC, 2, low cycles between consecutive change-coin pulses (≥1)

Ports:
Clk  in  1  clock
rst  in  1  synchronous, active-high reset
N  in  1  nickel sensor (level, held ≥1 cycle per coin)
D  in  1  dime sensor
Q  in  1  quarter sensor
sel_valid  in  1  selection strobe, 1 cycle
sel  in  2  product index
cancel  in  1  refund request, 1 cycle
credit  out  9  current credit in cents
busy  out  1  high in DISPENSE/CHANGE/GAP
coin_reject  out  1  1-cycle pulse: coin edge not credited
sel_nack  out  1  1-cycle pulse: selection refused
vend  out  1  1-cycle vend strobe
vend_id  out  2  product index, valid with vend, held until next vend
chg_q  out  1  1-cycle pulse: eject one quarter
chg_d  out  1  1-cycle pulse: eject one dime
chg_n  out  1  1-cycle pulse: eject one nickel

Behaviour:
- Reset (rst=1 at posedge Clk): state IDLE; all outputs 0; change register 0; timer 0; edge registers 0. Mid-transaction reset aborts with no refund and no partial pulses.
- Coin edge: a 0→1 transition on N, D or Q, taken from a registered previous value. Valid only if exactly one of the three rose in the cycle; two or more simultaneous rises → single coin_reject, no credit.
- Coin values: 5/10/25. If credit+value > MAX_CREDIT → coin_reject, credit unchanged. Coin edge while busy → coin_reject.
- States:
  - IDLE: credit 0. Valid coin → credit=value, go to COLLECT. sel_valid → sel_nack. cancel → ignored.
  - COLLECT: priority is cancel > coin > selection.
    - cancel → change=credit, go to CHANGE; a coin edge in the same cycle is rejected.
    - valid coin → credit += value, timer cleared; a sel_valid in the same cycle → sel_nack.
    - sel_valid with credit ≥ PRICE[sel] → change=credit−PRICE[sel], go to DISPENSE.
    - sel_valid with credit < PRICE[sel] → sel_nack, stay.
    - timer reaches TIMEOUT_CYC with no coin or sel_valid → change=credit, go to CHANGE. Any coin or sel_valid clears the timer.
  - DISPENSE (1 cycle): vend=1, vend_id=sel captured at selection; credit=0. If change=0 → IDLE, else → CHANGE.
  - CHANGE: greedy payout. If change≥25 → chg_q and change−=25; else if ≥10 → chg_d and −=10; else → chg_n and −=5. Exactly one pulse per cycle in this state. Go to GAP.
  - GAP: outputs low for GAP_CYC cycles. Then change≠0 → CHANGE, change=0 → IDLE with credit=0.
- Latency: sel_valid at cycle t → vend high in t+1 → first change pulse in t+2.
- credit is displayed during COLLECT. It is 0 from DISPENSE onward. For cancel/timeout it holds the refund value until CHANGE, then is 0.
- Arithmetic: 9-bit unsigned. Comparisons use prices zero-extended to 9 bits. A change value that is not a multiple of 5 cannot occur because prices and MAX_CREDIT are multiples of 5.

Decomposition:
- Shared package vend_pkg: coin value constants (5/10/25), state enum (IDLE, COLLECT, DISPENSE, CHANGE, GAP), default price constants, 9-bit cents type.
- One sub-module, change_dispenser. It takes a load strobe plus a 9-bit amount and drives chg_q/d/n with the GAP_CYC spacing, returning done.

Test Plan:
1. Q edge, then sel=0 → credit 25; vend=1 with vend_id=0 one cycle after sel_valid; no change pulses; back in IDLE.
2. Q,Q,D (credit 60), sel=1 → vend with id 1; then chg_d pulse, GAP_CYC cycles low, IDLE; credit 0.
3. N,D (credit 15), sel=2 → sel_nack, credit stays 15. Then cancel → chg_d, then chg_n; IDLE.
4. N and D rising in the same cycle → one coin_reject, credit 0. Q×7 (MAX_CREDIT=195) → 8th quarter rejected at credit 175.
5. D edge, then idle TIMEOUT_CYC cycles → chg_d refund; coin edge during GAP → coin_reject.
6. rst asserted during CHANGE with 40 pending → all outputs 0 the next cycle and no further chg pulses. Coin edge and sel_valid in the same cycle → coin credited, sel_nack.

Source files
------------

// File: rtl/vend_sequencer_pkg.sv
// Shared types and constants for the vending transaction controller.
// Coin values, default prices, the 9-bit cents type and the controller state enum.
package vend_pkg;

    typedef logic [8:0] cents_t;

    localparam cents_t NICKEL  = 9'd5;
    localparam cents_t DIME    = 9'd10;
    localparam cents_t QUARTER = 9'd25;

    localparam int PRICE0_DEF      = 25;
    localparam int PRICE1_DEF      = 50;
    localparam int PRICE2_DEF      = 65;
    localparam int PRICE3_DEF      = 100;
    localparam int MAX_CREDIT_DEF  = 195;
    localparam int TIMEOUT_CYC_DEF = 1000;
    localparam int GAP_CYC_DEF     = 2;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        DISPENSE,
        CHANGE,
        GAP
    } state_t;

    // Rise vector is ordered {quarter, dime, nickel}; anything but a single rise is worth nothing.
    function automatic cents_t coinValue(input logic [2:0] rise);
        case (rise)
            3'b001:  coinValue = NICKEL;
            3'b010:  coinValue = DIME;
            3'b100:  coinValue = QUARTER;
            default: coinValue = '0;
        endcase
    endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin, selection and mechanism signals between the vending controller and its surroundings.
interface vend_sequencer_if;
    import vend_pkg::*;

    logic       N;
    logic       D;
    logic       Q;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    cents_t     credit;
    logic       busy;
    logic       coin_reject;
    logic       sel_nack;
    logic       vend;
    logic [1:0] vend_id;
    logic       chg_q;
    logic       chg_d;
    logic       chg_n;

    modport slave (
        input  N, D, Q, sel_valid, sel, cancel,
        output credit, busy, coin_reject, sel_nack, vend, vend_id, chg_q, chg_d, chg_n
    );

    modport master (
        output N, D, Q, sel_valid, sel, cancel,
        input  credit, busy, coin_reject, sel_nack, vend, vend_id, chg_q, chg_d, chg_n
    );

endinterface

// File: rtl/vend_sequencer_change_dispenser.sv
// Greedy change payout: one coin pulse, then GAP_CYC quiet cycles, until the loaded amount is gone.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic   Clk,
    input  logic   rst,
    input  logic   load_i,
    input  cents_t amount_i,
    output logic   chgQ_o,
    output logic   chgD_o,
    output logic   chgN_o,
    output logic   payNext_o,
    output logic   done_o
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t         phase_q, phase_d;
    cents_t         amt_q, amt_d;
    logic [GW-1:0]  gapCnt_q, gapCnt_d;
    logic           gapLast;

    assign gapLast = (gapCnt_q == GW'(GAP_CYC - 1));

    always_ff @(posedge Clk) begin
        if (rst) begin
            phase_q  <= IDLE;
            amt_q    <= '0;
            gapCnt_q <= '0;
        end else begin
            phase_q  <= phase_d;
            amt_q    <= amt_d;
            gapCnt_q <= gapCnt_d;
        end
    end

    // payNext_o/done_o tell the controller, in the last quiet cycle, whether another coin follows.
    always_comb begin
        phase_d   = phase_q;
        amt_d     = amt_q;
        gapCnt_d  = gapCnt_q;
        chgQ_o    = 1'b0;
        chgD_o    = 1'b0;
        chgN_o    = 1'b0;
        payNext_o = 1'b0;
        done_o    = 1'b0;
        case (phase_q)
            IDLE: begin
                if (load_i && (amount_i != '0)) begin
                    amt_d   = amount_i;
                    phase_d = CHANGE;
                end
            end
            CHANGE: begin
                gapCnt_d = '0;
                phase_d  = GAP;
                if (amt_q >= QUARTER) begin
                    chgQ_o = 1'b1;
                    amt_d  = amt_q - QUARTER;
                end else if (amt_q >= DIME) begin
                    chgD_o = 1'b1;
                    amt_d  = amt_q - DIME;
                end else begin
                    chgN_o = 1'b1;
                    amt_d  = (amt_q > NICKEL) ? (amt_q - NICKEL) : '0;
                end
            end
            GAP: begin
                if (gapLast) begin
                    if (amt_q != '0) begin
                        payNext_o = 1'b1;
                        phase_d   = CHANGE;
                    end else begin
                        done_o  = 1'b1;
                        phase_d = IDLE;
                    end
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin edge detection, credit, selection, vend strobe and refunds.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0      = PRICE0_DEF,
    parameter int PRICE1      = PRICE1_DEF,
    parameter int PRICE2      = PRICE2_DEF,
    parameter int PRICE3      = PRICE3_DEF,
    parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF
) (
    input  logic           Clk,
    input  logic           rst,
    vend_sequencer_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state_q, state_d;
    cents_t        credit_q, credit_d;
    cents_t        change_q, change_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    vendId_q, vendId_d;
    logic          coinReject_q, coinReject_d;
    logic          selNack_q, selNack_d;
    logic          nPrev_q, dPrev_q, qPrev_q;

    logic [2:0]    rise;
    logic          anyRise, oneRise, fits, timerDone;
    logic [9:0]    sum;
    cents_t        price;
    logic          dispLoad, dispPayNext, dispDone;
    cents_t        dispAmount;

    assign rise      = {bus.Q & ~qPrev_q, bus.D & ~dPrev_q, bus.N & ~nPrev_q};
    assign anyRise   = |rise;
    assign oneRise   = $onehot(rise);
    assign sum       = {1'b0, credit_q} + {1'b0, coinValue(rise)};
    assign fits      = (sum <= 10'(MAX_CREDIT));
    assign timerDone = (timer_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        case (bus.sel)
            2'd0:    price = cents_t'(PRICE0);
            2'd1:    price = cents_t'(PRICE1);
            2'd2:    price = cents_t'(PRICE2);
            default: price = cents_t'(PRICE3);
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q      <= IDLE;
            credit_q     <= '0;
            change_q     <= '0;
            timer_q      <= '0;
            vendId_q     <= '0;
            coinReject_q <= 1'b0;
            selNack_q    <= 1'b0;
            nPrev_q      <= 1'b0;
            dPrev_q      <= 1'b0;
            qPrev_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            change_q     <= change_d;
            timer_q      <= timer_d;
            vendId_q     <= vendId_d;
            coinReject_q <= coinReject_d;
            selNack_q    <= selNack_d;
            nPrev_q      <= bus.N;
            dPrev_q      <= bus.D;
            qPrev_q      <= bus.Q;
        end
    end

    // Any coin edge is rejected unless a branch below explicitly credits it.
    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        change_d     = change_q;
        timer_d      = timer_q;
        vendId_d     = vendId_q;
        coinReject_d = anyRise;
        selNack_d    = 1'b0;
        dispLoad     = 1'b0;
        dispAmount   = change_q;
        case (state_q)
            IDLE: begin
                credit_d  = '0;
                selNack_d = bus.sel_valid;
                if (oneRise && fits) begin
                    credit_d     = sum[8:0];
                    timer_d      = '0;
                    coinReject_d = 1'b0;
                    state_d      = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.cancel || (!anyRise && !bus.sel_valid && timerDone)) begin
                    selNack_d  = bus.sel_valid;
                    dispLoad   = 1'b1;
                    dispAmount = credit_q;
                    credit_d   = '0;
                    state_d    = CHANGE;
                end else if (anyRise) begin
                    timer_d   = '0;
                    selNack_d = bus.sel_valid;
                    if (oneRise && fits) begin
                        credit_d     = sum[8:0];
                        coinReject_d = 1'b0;
                    end
                end else if (bus.sel_valid) begin
                    timer_d = '0;
                    if (credit_q >= price) begin
                        change_d = credit_q - price;
                        vendId_d = bus.sel;
                        credit_d = '0;
                        state_d  = DISPENSE;
                    end else begin
                        selNack_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DISPENSE: begin
                credit_d = '0;
                dispLoad = 1'b1;
                state_d  = (change_q == '0) ? IDLE : CHANGE;
            end
            CHANGE: state_d = GAP;
            GAP: begin
                if (dispDone) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end else if (dispPayNext) begin
                    state_d = CHANGE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    change_dispenser #(
        .GAP_CYC(GAP_CYC)
    ) uDispenser (
        .Clk       (Clk),
        .rst       (rst),
        .load_i    (dispLoad),
        .amount_i  (dispAmount),
        .chgQ_o    (bus.chg_q),
        .chgD_o    (bus.chg_d),
        .chgN_o    (bus.chg_n),
        .payNext_o (dispPayNext),
        .done_o    (dispDone)
    );

    assign bus.credit      = credit_q;
    assign bus.busy        = (state_q == DISPENSE) || (state_q == CHANGE) || (state_q == GAP);
    assign bus.vend        = (state_q == DISPENSE);
    assign bus.vend_id     = vendId_q;
    assign bus.coin_reject = coinReject_q;
    assign bus.sel_nack    = selNack_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with hand-computed expectations (default parameters).
module tb_vend_sequencer;

    logic Clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    vend_sequencer_if bus ();

    vend_sequencer uDut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input int unsigned observed, input int unsigned expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the active edge.
    task automatic applyStimulus(input logic n, input logic d, input logic q,
                                 input logic sv, input logic [1:0] s, input logic c);
        bus.N         = n;
        bus.D         = d;
        bus.Q         = q;
        bus.sel_valid = sv;
        bus.sel       = s;
        bus.cancel    = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic waitIdle(input string tag);
        int cnt = 0;
        while (bus.busy && cnt < 200) begin
            tick();
            cnt++;
        end
        checkOutput(tag, bus.busy, 0);
    endtask

    function automatic logic [2:0] chg();
        return {bus.chg_q, bus.chg_d, bus.chg_n};
    endfunction

    initial begin
        int cnt;
        logic [2:0] seen;

        rst = 1'b1;
        tick();
        tick();
        checkOutput("resetOuts", {bus.busy, bus.coin_reject, bus.sel_nack, bus.vend, chg(), bus.vend_id}, 0);
        checkOutput("resetCredit", bus.credit, 0);
        rst = 1'b0;
        tick();

        // Exact-price purchase, no change.
        applyStimulus(0, 0, 1, 0, 2'd0, 0);
        checkOutput("t1Credit", bus.credit, 25);
        tick();
        applyStimulus(0, 0, 0, 1, 2'd0, 0);
        checkOutput("t1Vend", bus.vend, 1);
        checkOutput("t1VendId", bus.vend_id, 0);
        checkOutput("t1CreditZero", bus.credit, 0);
        tick();
        checkOutput("t1NoChange", chg(), 0);
        checkOutput("t1Idle", bus.busy, 0);

        // 60 cents buys product 1 and returns a dime.
        applyStimulus(0, 0, 1, 0, 2'd0, 0); tick();
        applyStimulus(0, 0, 1, 0, 2'd0, 0); tick();
        applyStimulus(0, 1, 0, 0, 2'd0, 0);
        checkOutput("t2Credit", bus.credit, 60);
        tick();
        applyStimulus(0, 0, 0, 1, 2'd1, 0);
        checkOutput("t2Vend", bus.vend, 1);
        checkOutput("t2VendId", bus.vend_id, 1);
        tick();
        checkOutput("t2Dime", chg(), 3'b010);
        tick();
        checkOutput("t2Gap1", {bus.busy, chg()}, 4'b1000);
        tick();
        checkOutput("t2Gap2", {bus.busy, chg()}, 4'b1000);
        tick();
        checkOutput("t2Idle", bus.busy, 0);
        checkOutput("t2CreditZero", bus.credit, 0);
        checkOutput("t2IdHeld", bus.vend_id, 1);

        // Too little credit, then cancel refunds a dime and a nickel.
        applyStimulus(1, 0, 0, 0, 2'd0, 0); tick();
        applyStimulus(0, 1, 0, 0, 2'd0, 0); tick();
        checkOutput("t3Credit", bus.credit, 15);
        applyStimulus(0, 0, 0, 1, 2'd2, 0);
        checkOutput("t3Nack", bus.sel_nack, 1);
        checkOutput("t3CreditKept", bus.credit, 15);
        applyStimulus(0, 0, 0, 0, 2'd0, 1);
        checkOutput("t3RefundDime", chg(), 3'b010);
        tick(); tick(); tick();
        checkOutput("t3RefundNickel", chg(), 3'b001);
        tick(); tick(); tick();
        checkOutput("t3Idle", bus.busy, 0);

        // Simultaneous rises, then credit ceiling.
        applyStimulus(1, 1, 0, 0, 2'd0, 0);
        checkOutput("t4MultiReject", bus.coin_reject, 1);
        checkOutput("t4MultiCredit", bus.credit, 0);
        tick();
        checkOutput("t4RejectPulse", bus.coin_reject, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 0, 2'd0, 0);
            tick();
        end
        checkOutput("t4Credit175", bus.credit, 175);
        applyStimulus(0, 0, 1, 0, 2'd0, 0);
        checkOutput("t4OverReject", bus.coin_reject, 1);
        checkOutput("t4OverCredit", bus.credit, 175);
        tick();
        applyStimulus(0, 0, 0, 0, 2'd0, 1);
        waitIdle("t4Drain");

        // Inactivity timeout refunds the dime; a coin during the gap is refused.
        applyStimulus(0, 1, 0, 0, 2'd0, 0);
        checkOutput("t5Credit", bus.credit, 10);
        cnt = 0;
        while (!bus.chg_d && cnt < 1100) begin
            tick();
            cnt++;
        end
        checkOutput("t5TimeoutCycles", cnt, 1000);
        applyStimulus(0, 0, 1, 0, 2'd0, 0);
        checkOutput("t5BusyReject", bus.coin_reject, 1);
        checkOutput("t5BusyCredit", bus.credit, 0);
        waitIdle("t5Drain");

        // Reset in the middle of a 40-cent refund.
        applyStimulus(0, 0, 1, 0, 2'd0, 0); tick();
        applyStimulus(0, 1, 0, 0, 2'd0, 0); tick();
        applyStimulus(1, 0, 0, 0, 2'd0, 0); tick();
        checkOutput("t6Credit", bus.credit, 40);
        applyStimulus(0, 0, 0, 0, 2'd0, 1);
        checkOutput("t6Quarter", chg(), 3'b100);
        rst = 1'b1;
        tick();
        checkOutput("t6ResetOuts", {bus.busy, bus.coin_reject, bus.sel_nack, bus.vend, chg(), bus.vend_id}, 0);
        checkOutput("t6ResetCredit", bus.credit, 0);
        rst = 1'b0;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= chg();
        end
        checkOutput("t6NoPulses", seen, 0);

        // Coin beats selection in the same cycle.
        applyStimulus(0, 0, 1, 0, 2'd0, 0); tick();
        applyStimulus(0, 1, 0, 1, 2'd0, 0);
        checkOutput("t6CoinCredit", bus.credit, 35);
        checkOutput("t6SelNack", bus.sel_nack, 1);
        checkOutput("t6NoVend", bus.vend, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 2'd0, 1);
        waitIdle("t6Drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
